accum_tree_ctrl: RTL and testbench

ACCUM_TREE_CTRL -- requirements
Module: accum_tree_ctrl

---
 rtl/accum_pkg.sv | 16 +
 rtl/accum_inflight_pipe.sv | 26 ++
 rtl/accum_tree_ctrl.sv | 147 ++++++++++++++
 tb/tb_accum_tree_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/accum_pkg.sv
// Shared defaults, state encoding and constants for the accumulator-tree controller.
package accum_pkg;

  localparam int DEF_TREE_LAT = 3;
  localparam int DEF_LEN_W    = 8;
  localparam int DEF_ACC_W    = 32;
  localparam int NUM_PRODUCTS = 12;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/accum_inflight_pipe.sv
// Valid-bit delay line that marks when an issued beat's sum emerges from the tree.
module accum_inflight_pipe #(
  parameter int DEPTH = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in,
  output logic out
);

  logic [DEPTH-1:0] stage;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage <= '0;
    end else begin
      stage[0] <= in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out = stage[DEPTH-1];

endmodule

// File: rtl/accum_tree_ctrl.sv
// Job controller for a pipelined 12-product accumulator tree: issues beats, folds returns into acc.
// Define ACC_SAT_EN to saturate the accumulator on overflow instead of wrapping.
module accum_tree_ctrl
  import accum_pkg::*;
#(
  parameter int TREE_LAT = DEF_TREE_LAT,
  parameter int LEN_W    = DEF_LEN_W,
  parameter int ACC_W    = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [ACC_W-1:0] cfg_bias,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             tree_prod_en,
  output logic [ACC_W-1:0] tree_partial_sum,
  input  logic [ACC_W-1:0] tree_sum,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf
);

  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [LEN_W-1:0] len_q;
  logic [ACC_W-1:0] bias_q;
  logic [LEN_W-1:0] issue_cnt;
  logic [LEN_W-1:0] ret_cnt;
  logic [ACC_W-1:0] acc;
  logic             ovf;
  logic             issue;
  logic             issue_last;
  logic             ret;
  logic             ret_last;
  logic             accept_start;
  logic [ACC_W:0]   acc_sum;
  logic [ACC_W-1:0] acc_nxt;

  assign accept_start = (state == IDLE) && start;
  assign issue        = in_valid && in_ready;
  assign issue_last   = issue && ((issue_cnt + LEN_ONE) == len_q);
  assign ret_last     = ret && ((ret_cnt + LEN_ONE) == len_q);

  assign tree_prod_en     = issue;
  // Bias rides into the tree with the first beat, so acc itself starts from zero.
  assign tree_partial_sum = (issue && (issue_cnt == '0)) ? bias_q : '0;

  accum_inflight_pipe #(
    .DEPTH (TREE_LAT)
  ) u_inflight_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (issue),
    .out   (ret)
  );

  assign acc_sum = {1'b0, acc} + {1'b0, tree_sum};

`ifdef ACC_SAT_EN
  assign acc_nxt = acc_sum[ACC_W] ? {ACC_W{1'b1}} : acc_sum[ACC_W-1:0];
`else
  assign acc_nxt = acc_sum[ACC_W-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = 1'b1;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start) begin
          state_nxt = (cfg_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (issue_last) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (ret_last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Config is captured only on an accepted start; a zero-length job takes the bias as its result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q     <= '0;
      bias_q    <= '0;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      acc       <= '0;
      ovf       <= 1'b0;
    end else if (accept_start) begin
      len_q     <= cfg_len;
      bias_q    <= cfg_bias;
      issue_cnt <= '0;
      ret_cnt   <= '0;
      acc       <= (cfg_len == '0) ? cfg_bias : '0;
      ovf       <= 1'b0;
    end else begin
      if (issue) begin
        issue_cnt <= issue_cnt + LEN_ONE;
      end
      if (ret) begin
        acc     <= acc_nxt;
        ret_cnt <= ret_cnt + LEN_ONE;
        if (acc_sum[ACC_W]) begin
          ovf <= 1'b1;
        end
      end
    end
  end

  assign out_data = out_valid ? acc : '0;
  assign out_ovf  = ovf;

endmodule

// File: tb/tb_accum_tree_ctrl.sv
// Self-checking bench for accum_tree_ctrl with a behavioural 3-cycle, 12-product tree model.
module tb_accum_tree_ctrl;
  import accum_pkg::*;

  localparam int TREE_LAT = 3;
  localparam int LEN_W    = 8;
  localparam int ACC_W    = 32;

  typedef struct packed {
    logic [7:0]       len;
    logic [31:0]      bias;
    logic [3:0][31:0] beats;
    logic [3:0][7:0]  gaps;
    logic [31:0]      exp_data;
    logic             exp_ovf;
  } vec_t;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] cfg_len;
  logic [ACC_W-1:0] cfg_bias;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic             tree_prod_en;
  logic [ACC_W-1:0] tree_partial_sum;
  logic [ACC_W-1:0] tree_sum;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  logic [31:0] prod [NUM_PRODUCTS];
  logic [31:0] s0, s1, s2;

  int   checks;
  int   failures;
  int   cyc;
  int   issue_total;
  int   job_base;
  int   last_issue;
  int   valid_rise;
  int   start_cyc;
  logic prev_valid;
  logic [31:0] cur_bias;
  exp_t sb[$];
  vec_t vecs[6];

  accum_tree_ctrl #(
    .TREE_LAT (TREE_LAT),
    .LEN_W    (LEN_W),
    .ACC_W    (ACC_W)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .start            (start),
    .cfg_len          (cfg_len),
    .cfg_bias         (cfg_bias),
    .busy             (busy),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .tree_prod_en     (tree_prod_en),
    .tree_partial_sum (tree_partial_sum),
    .tree_sum         (tree_sum),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_data         (out_data),
    .out_ovf          (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Tree model: gated products plus partial sum, three register stages deep.
  always @(posedge clk or negedge rst_n) begin : tree_model
    logic [31:0] tot;
    if (!rst_n) begin
      s0 <= '0;
      s1 <= '0;
      s2 <= '0;
    end else begin
      tot = tree_partial_sum;
      if (tree_prod_en) begin
        for (int i = 0; i < NUM_PRODUCTS; i++) tot = tot + prod[i];
      end
      s0 <= tot;
      s1 <= s0;
      s2 <= s1;
    end
  end
  assign tree_sum = s2;

  function automatic void checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
    end
  endfunction

  // Split a beat total across the product lanes so the model really adds 12 terms.
  function automatic void set_beat(input logic [31:0] v);
    logic [31:0] part;
    part = v / 32'(NUM_PRODUCTS);
    for (int i = 0; i < NUM_PRODUCTS - 1; i++) prod[i] = part;
    prod[NUM_PRODUCTS-1] = v - part * 32'(NUM_PRODUCTS - 1);
  endfunction

  function automatic vec_t mk(input logic [7:0] len, input logic [31:0] bias,
                              input logic [31:0] b0, input logic [31:0] b1,
                              input logic [31:0] b2, input logic [31:0] b3,
                              input logic [7:0] g0, input logic [7:0] g1,
                              input logic [7:0] g2, input logic [7:0] g3,
                              input logic [31:0] exp_data, input logic exp_ovf);
    vec_t v;
    v.len      = len;
    v.bias     = bias;
    v.beats[0] = b0;
    v.beats[1] = b1;
    v.beats[2] = b2;
    v.beats[3] = b3;
    v.gaps[0]  = g0;
    v.gaps[1]  = g1;
    v.gaps[2]  = g2;
    v.gaps[3]  = g3;
    v.exp_data = exp_data;
    v.exp_ovf  = exp_ovf;
    return v;
  endfunction

  // Monitor on the falling edge, away from where the DUT updates.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (tree_prod_en) begin
        checkOutput("partial_sum_issue", tree_partial_sum,
                    (issue_total == job_base) ? cur_bias : 32'h0);
        issue_total = issue_total + 1;
        last_issue  = cyc;
      end else begin
        checkOutput("partial_sum_quiet", tree_partial_sum, 0);
      end
      if (start && !busy) start_cyc = cyc;
      if (out_valid && !prev_valid) valid_rise = cyc;
      prev_valid = out_valid;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", sb.size(), 1);
        end else begin
          e = sb.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_ovf", out_ovf, e.ovf);
        end
      end
    end else begin
      prev_valid = 1'b0;
    end
  end

  task automatic send_beat(input logic [31:0] v, input int gap);
    in_valid = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    set_beat(v);
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) checkOutput("beat_accept_timeout", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input bit wait_done);
    exp_t e;
    e.data    = v.exp_data;
    e.ovf     = v.exp_ovf;
    sb.push_back(e);
    cur_bias  = v.bias;
    job_base  = issue_total;
    start     = 1'b1;
    cfg_len   = v.len;
    cfg_bias  = v.bias;
    @(posedge clk);
    #1;
    start     = 1'b0;
    cfg_len   = 8'hAA;
    cfg_bias  = 32'hBAD0_BAD0;
    for (int i = 0; i < int'(v.len); i++) send_beat(v.beats[i], int'(v.gaps[i]));
    if (wait_done) begin
      for (int i = 0; i < 60 && busy; i++) begin
        @(posedge clk);
        #1;
      end
      checkOutput("job_done", busy, 0);
      checkOutput("issue_count", issue_total - job_base, v.len);
      if (v.len != 0) checkOutput("issue_to_valid", valid_rise - last_issue, TREE_LAT + 1);
      else            checkOutput("start_to_valid", valid_rise - start_cyc, 1);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"}, busy, 0);
    checkOutput({tag, "_in_ready"}, in_ready, 0);
    checkOutput({tag, "_prod_en"}, tree_prod_en, 0);
    checkOutput({tag, "_partial"}, tree_partial_sum, 0);
    checkOutput({tag, "_out_valid"}, out_valid, 0);
    checkOutput({tag, "_out_data"}, out_data, 0);
    checkOutput({tag, "_out_ovf"}, out_ovf, 0);
  endtask

  initial begin
    vec_t hold_job;
    checks      = 0;
    failures    = 0;
    cyc         = 0;
    issue_total = 0;
    job_base    = 0;
    last_issue  = 0;
    valid_rise  = 0;
    start_cyc   = 0;
    prev_valid  = 1'b0;
    cur_bias    = '0;
    rst_n       = 1'b0;
    start       = 1'b0;
    cfg_len     = '0;
    cfg_bias    = '0;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    set_beat(32'h0);

    vecs[0] = mk(8'd4, 32'd10, 32'd5, 32'd6, 32'd7, 32'd8, 8'd0, 8'd0, 8'd0, 8'd0, 32'd36, 1'b0);
    vecs[1] = mk(8'd3, 32'h100, 32'h11, 32'h22, 32'h33, 32'h0, 8'd0, 8'd2, 8'd1, 8'd0, 32'h166, 1'b0);
    vecs[2] = mk(8'd0, 32'h55, 32'h0, 32'h0, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0, 32'h55, 1'b0);
`ifdef ACC_SAT_EN
    vecs[3] = mk(8'd2, 32'hFFFF_FFF0, 32'h5, 32'h10, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0, 32'hFFFF_FFFF, 1'b1);
`else
    vecs[3] = mk(8'd2, 32'hFFFF_FFF0, 32'h5, 32'h10, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0, 32'h5, 1'b1);
`endif
    vecs[4] = mk(8'd4, 32'd7, 32'h1000, 32'h2000, 32'h3000, 32'h4000, 8'd1, 8'd0, 8'd3, 8'd0, 32'hA007, 1'b0);
    vecs[5] = mk(8'd1, 32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0, 8'd2, 8'd0, 8'd0, 8'd0, 32'hDEAD_BEEF, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) begin
      $display("[TB] vector %0d len=%0d bias=0x%0h", i, vecs[i].len, vecs[i].bias);
      applyStimulus(vecs[i], 1'b1);
    end

    // Consumer stalls in DONE while a stray start arrives.
    $display("[TB] hold sequence");
    out_ready = 1'b0;
    hold_job  = mk(8'd2, 32'd3, 32'd1, 32'd2, 32'h0, 32'h0, 8'd0, 8'd0, 8'd0, 8'd0, 32'd6, 1'b0);
    applyStimulus(hold_job, 1'b0);
    for (int i = 0; i < 40 && !out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("hold_valid_rise", out_valid, 1);
    for (int k = 0; k < 5; k++) begin
      start    = (k == 1);
      cfg_len  = 8'd5;
      cfg_bias = 32'h999;
      @(posedge clk);
      #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_data", out_data, 6);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("idle_after_handshake", busy, 0);
    checkOutput("valid_after_handshake", out_valid, 0);
    @(posedge clk);
    #1;
    checkOutput("stray_start_ignored", busy, 0);

    // Reset lands in RUN after two of four beats.
    $display("[TB] reset-abort sequence");
    cur_bias = 32'd10;
    job_base = issue_total;
    start    = 1'b1;
    cfg_len  = 8'd4;
    cfg_bias = 32'd10;
    @(posedge clk);
    #1;
    start = 1'b0;
    send_beat(32'd5, 0);
    send_beat(32'd6, 0);
    rst_n = 1'b0;
    #1;
    checkResetOutputs("abort");
    repeat (2) @(posedge clk);
    #1;
    checkResetOutputs("abort_hold");
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(vecs[0], 1'b1);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("sb_empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
